// File: rtl/deser16_pkg.sv
// deser16_pkg: word/counter widths and types shared by the deser16 1:16 deserializer.
package deser16_pkg;

  localparam int DESER_W = 16;
  localparam int CNT_W   = 4;

  typedef logic [DESER_W-1:0] deser_word_t;
  typedef logic [CNT_W-1:0]   deser_cnt_t;

  localparam deser_cnt_t CNT_LAST = deser_cnt_t'(DESER_W - 1);

endpackage

// File: rtl/deser16_slip.sv
// deser16_slip: CALIB rising-edge detector holding at most one pending bitslip.
module deser16_slip
  import deser16_pkg::*;
(
  input  logic CLK,
  input  logic RESETN,
  input  logic CALIB,
  input  logic i_consume,
  output logic o_slip_pend
);

  logic r_calib_d;
  logic r_slip_pend;
  logic w_rise;

  assign w_rise = CALIB & ~r_calib_d;

  // Consumption wins over a new edge, so edges arriving while a slip is pending are absorbed.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_calib_d   <= 1'b0;
      r_slip_pend <= 1'b0;
    end else begin
      r_calib_d <= CALIB;
      if (i_consume) begin
        r_slip_pend <= 1'b0;
      end else if (w_rise) begin
        r_slip_pend <= 1'b1;
      end
    end
  end

  assign o_slip_pend = r_slip_pend;

endmodule

// File: rtl/deser16.sv
// deser16: 1:16 serial-to-parallel deserializer with CALIB-driven bitslip.
// Optional macro DESER16_BITCNT_EN adds the BITCNT debug output (current bit index).
module deser16
  import deser16_pkg::*;
#(
  parameter bit          LSB_FIRST = 1'b1,
  parameter deser_word_t Q_INIT    = '0
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        CE,
  input  logic        D,
  input  logic        CALIB,
  output deser_word_t Q,
  output logic        VALID
`ifdef DESER16_BITCNT_EN
  ,
  output deser_cnt_t  BITCNT
`endif
);

  deser_word_t r_sreg;
  deser_word_t r_q;
  deser_cnt_t  r_cnt;
  logic        r_valid;

  deser_word_t w_shifted;
  logic        w_slip_pend;
  logic        w_consume;

  assign w_consume = CE & w_slip_pend;

  deser16_slip u_slip (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .CALIB       (CALIB),
    .i_consume   (w_consume),
    .o_slip_pend (w_slip_pend)
  );

  always_comb begin
    if (LSB_FIRST) begin
      w_shifted = {D, r_sreg[DESER_W-1:1]};
    end else begin
      w_shifted = {r_sreg[DESER_W-2:0], D};
    end
  end

  // A slipped bit is shifted but not counted, stretching that word by one bit.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_q     <= Q_INIT;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (CE) begin
        r_sreg <= w_shifted;
        if (!w_slip_pend) begin
          if (r_cnt == CNT_LAST) begin
            r_q     <= w_shifted;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + deser_cnt_t'(1);
          end
        end
      end
    end
  end

  assign Q     = r_q;
  assign VALID = r_valid;
`ifdef DESER16_BITCNT_EN
  assign BITCNT = r_cnt;
`endif

endmodule

// File: tb/tb_deser16.sv
// tb_deser16: table vectors, bitslip/reset sequences and random traffic against a bit-history model.
module tb_deser16;
  import deser16_pkg::*;

  localparam deser_word_t MSB_INIT = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rstN;
  logic        ce;
  logic        d;
  logic        calib;
  deser_word_t qLsb;
  deser_word_t qMsb;
  logic        validLsb;
  logic        validMsb;
`ifdef DESER16_BITCNT_EN
  deser_cnt_t  bitcntLsb;
  deser_cnt_t  bitcntMsb;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int edgeCount   = 0;
  int streamIdx   = 0;
  int validEdges[$];

  // Model: the completed word is simply the last 16 received bits; a slip adds one uncounted bit.
  bit          hist[$];
  int          mBits;
  bit          mPend;
  bit          mCalibD;
  logic [15:0] expQLsb;
  logic [15:0] expQMsb;
  logic        expValid;

  typedef struct {
    string       name;
    logic [15:0] word;
    bit          msbFirst;
    bit          ceGap;
    logic [15:0] expLsb;
    logic [15:0] expMsb;
    int          expEdge;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  deser16 #(.LSB_FIRST(1'b1), .Q_INIT(16'h0000)) dut (
    .CLK    (clk),
    .RESETN (rstN),
    .CE     (ce),
    .D      (d),
    .CALIB  (calib),
    .Q      (qLsb),
    .VALID  (validLsb)
`ifdef DESER16_BITCNT_EN
    ,
    .BITCNT (bitcntLsb)
`endif
  );

  deser16 #(.LSB_FIRST(1'b0), .Q_INIT(MSB_INIT)) dutMsb (
    .CLK    (clk),
    .RESETN (rstN),
    .CE     (ce),
    .D      (d),
    .CALIB  (calib),
    .Q      (qMsb),
    .VALID  (validMsb)
`ifdef DESER16_BITCNT_EN
    ,
    .BITCNT (bitcntMsb)
`endif
  );

  function automatic logic [15:0] packWord(input bit lsbFirst);
    logic [15:0] w;
    int base;
    w = '0;
    base = hist.size() - 16;
    for (int k = 0; k < 16; k++) begin
      if (lsbFirst) w[k] = hist[base + k];
      else          w[15 - k] = hist[base + k];
    end
    return w;
  endfunction

  task automatic modelReset();
    hist.delete();
    mBits    = 0;
    mPend    = 1'b0;
    mCalibD  = 1'b0;
    expQLsb  = 16'h0000;
    expQMsb  = MSB_INIT;
    expValid = 1'b0;
  endtask

  task automatic modelStep(input logic ceIn, input logic dIn, input logic calibIn);
    bit oldPend;
    oldPend  = mPend;
    expValid = 1'b0;
    if (ceIn) begin
      hist.push_back(dIn);
      if (hist.size() > 16) void'(hist.pop_front());
      if (oldPend) begin
        mPend = 1'b0;
      end else begin
        mBits++;
        if (mBits == 16) begin
          mBits    = 0;
          expValid = 1'b1;
          expQLsb  = packWord(1'b1);
          expQMsb  = packWord(1'b0);
        end
      end
    end
    if (!oldPend && calibIn && !mCalibD) mPend = 1'b1;
    mCalibD = calibIn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " valid"}, 32'(validLsb), 32'(expValid));
    checkOutput({tag, " validMsb"}, 32'(validMsb), 32'(expValid));
    checkOutput({tag, " qLsb"}, 32'(qLsb), 32'(expQLsb));
    checkOutput({tag, " qMsb"}, 32'(qMsb), 32'(expQMsb));
`ifdef DESER16_BITCNT_EN
    checkOutput({tag, " bitcnt"}, 32'(bitcntLsb), 32'(mBits));
    checkOutput({tag, " bitcntMsb"}, 32'(bitcntMsb), 32'(mBits));
`endif
  endtask

  // Called at a falling edge; drives inputs, steps one rising edge, checks, returns at the next falling edge.
  task automatic applyStimulus(input logic ceIn, input logic dIn, input logic calibIn);
    ce    = ceIn;
    d     = dIn;
    calib = calibIn;
    @(posedge clk);
    edgeCount++;
    modelStep(ceIn, dIn, calibIn);
    #1;
    checkAll("tick");
    if (validLsb === 1'b1) validEdges.push_back(edgeCount);
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN  = 1'b0;
    ce    = 1'($urandom);
    d     = 1'($urandom);
    calib = 1'($urandom);
    #2;
    modelReset();
    checkAll("reset async");
    @(posedge clk);
    #1;
    checkAll("reset held");
    @(negedge clk);
    rstN  = 1'b1;
    ce    = 1'b0;
    calib = 1'b0;
    edgeCount = 0;
    streamIdx = 0;
    validEdges.delete();
  endtask

  task automatic sendPattern0001(input int nBits, input int calibTicks);
    for (int i = 0; i < nBits; i++) begin
      applyStimulus(1'b1, logic'((streamIdx % 16) == 0), logic'(i < calibTicks));
      streamIdx++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n16;
    int n17;
    int nOther;

    vecs[0] = '{"A5C3 lsb-first", 16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 16'hC3A5, 16};
    vecs[1] = '{"A5C3 msb-first", 16'hA5C3, 1'b1, 1'b0, 16'hC3A5, 16'hA5C3, 16};
    vecs[2] = '{"00FF ce gaps",   16'h00FF, 1'b0, 1'b1, 16'h00FF, 16'hFF00, 32};
    vecs[3] = '{"BEEF lsb-first", 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 16'hF77D, 16};
    vecs[4] = '{"1234 msb-first", 16'h1234, 1'b1, 1'b0, 16'h2C48, 16'h1234, 16};

    rstN  = 1'b0;
    ce    = 1'b0;
    d     = 1'b0;
    calib = 1'b0;
    modelReset();
    @(negedge clk);

    $display("[TB] reset and idle CE=0");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'($urandom), 1'b0);
    checkOutput("idle no valid", 32'(validEdges.size()), 32'd0);
    checkOutput("idle q", 32'(qLsb), 32'h0000);

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++) begin
      doReset();
      for (int i = 0; i < 16; i++) begin
        if (vecs[v].ceGap) applyStimulus(1'b0, 1'($urandom), 1'b0);
        applyStimulus(1'b1, vecs[v].msbFirst ? vecs[v].word[15 - i] : vecs[v].word[i], 1'b0);
      end
      checkOutput({vecs[v].name, " qLsb"}, 32'(qLsb), 32'(vecs[v].expLsb));
      checkOutput({vecs[v].name, " qMsb"}, 32'(qMsb), 32'(vecs[v].expMsb));
      checkOutput({vecs[v].name, " valid count"}, 32'(validEdges.size()), 32'd1);
      if (validEdges.size() > 0)
        checkOutput({vecs[v].name, " valid edge"}, 32'(validEdges[0]), 32'(vecs[v].expEdge));
    end

    $display("[TB] back-to-back words");
    doReset();
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = (i < 16) ? 16'hA5C3 : 16'h1234;
      applyStimulus(1'b1, w[i % 16], 1'b0);
      if (i == 15) checkOutput("b2b word1", 32'(qLsb), 32'hA5C3);
    end
    checkOutput("b2b word2", 32'(qLsb), 32'h1234);
    checkOutput("b2b valid count", 32'(validEdges.size()), 32'd2);
    if (validEdges.size() == 2) begin
      checkOutput("b2b edge1", 32'(validEdges[0]), 32'd16);
      checkOutput("b2b edge2", 32'(validEdges[1]), 32'd32);
    end

    $display("[TB] bitslip");
    doReset();
    sendPattern0001(48, 0);
    checkOutput("slip aligned", 32'(qLsb), 32'h0001);
    sendPattern0001(96, 2);
    checkOutput("slip one", 32'(qLsb), 32'h8000);
    n16 = 0;
    n17 = 0;
    nOther = 0;
    for (int i = 1; i < validEdges.size(); i++) begin
      int gap;
      gap = validEdges[i] - validEdges[i - 1];
      if (gap == 16)      n16++;
      else if (gap == 17) n17++;
      else                nOther++;
    end
    checkOutput("slip stretched periods", 32'(n17), 32'd1);
    checkOutput("slip odd periods", 32'(nOther), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendPattern0001(48, 0);
    checkOutput("slip absorbed edge", 32'(qLsb), 32'h4000);

    $display("[TB] reset mid-word");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'($urandom), 1'b0);
    doReset();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'hBEEF;
      applyStimulus(1'b1, w[i], 1'b0);
    end
    checkOutput("midreset q", 32'(qLsb), 32'hBEEF);
    checkOutput("midreset valid count", 32'(validEdges.size()), 32'd1);
    if (validEdges.size() > 0) checkOutput("midreset edge", 32'(validEdges[0]), 32'd16);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0), 1'($urandom), logic'($urandom_range(0, 19) == 0));
    end
    checkOutput("random produced words", 32'(validEdges.size() > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
